// File: rtl/pipe_pkg.sv
// Shared definitions for the flow-controlled pipeline stage registers:
// handshake state encodings and packed payload layouts for each stage boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } ps_state_e;

  // IF/ID: pc + instruction
  localparam int IF_ID_W  = 32 + 32;
  // ID/EX: rd + pc + rs1 + rs2 + imm + alu_op + ctrl
  localparam int ID_EX_W  = 5 + 32 + 32 + 32 + 32 + 5 + 8;
  // EX/MEM: rd + pc + alu_result + rs2 + ctrl
  localparam int EX_MEM_W = 5 + 32 + 32 + 32 + 6;
  // MEM/WB: rd + pc + alu_result + mem_data + imm + wb_sel + reg_we
  localparam int MEM_WB_W = 5 + 32 + 32 + 32 + 32 + 2 + 1;

  // MEM/WB field offsets (LSB position of each field)
  localparam int MEM_WB_REG_WE_OFF = 0;
  localparam int MEM_WB_WB_SEL_OFF = MEM_WB_REG_WE_OFF + 1;
  localparam int MEM_WB_IMM_OFF    = MEM_WB_WB_SEL_OFF + 2;
  localparam int MEM_WB_MEM_OFF    = MEM_WB_IMM_OFF + 32;
  localparam int MEM_WB_ALU_OFF    = MEM_WB_MEM_OFF + 32;
  localparam int MEM_WB_PC_OFF     = MEM_WB_ALU_OFF + 32;
  localparam int MEM_WB_RD_OFF     = MEM_WB_PC_OFF + 32;

  // IF/ID field offsets
  localparam int IF_ID_INSTR_OFF = 0;
  localparam int IF_ID_PC_OFF    = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with a one-entry skid buffer so IN_READY is a pure
// register decode, plus synchronous flush and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] RESET_VALUE = {DATA_W{1'b0}},
  parameter int                CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              BUSYWAIT,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CNT_W-1:0]  STALL_CNT
);

  ps_state_e         state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_acc;
  logic              out_acc;

  assign OUT_VALID = (state_q != PS_EMPTY);
  assign IN_READY  = (state_q != PS_FULL);
  assign OUT_DATA  = main_q;

  assign in_acc  = IN_VALID & IN_READY;
  assign out_acc = OUT_VALID & OUT_READY & ~BUSYWAIT;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      PS_EMPTY: begin
        if (in_acc) begin
          state_d = PS_BUSY;
          main_d  = IN_DATA;
        end
      end
      PS_BUSY: begin
        if (in_acc && out_acc) begin
          main_d = IN_DATA;
        end else if (in_acc) begin
          state_d = PS_FULL;
          skid_d  = IN_DATA;
        end else if (out_acc) begin
          state_d = PS_EMPTY;
        end
      end
      PS_FULL: begin
        // Skid drains into main; no input is taken because IN_READY is low.
        if (out_acc) begin
          state_d = PS_BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = PS_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      state_q <= PS_EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Flush leaves the stall statistics intact; only reset clears them.
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i (CLK),
    .clr_i (RESET),
    .en_i  (OUT_VALID & ~out_acc),
    .cnt_o (STALL_CNT)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic, checked every
// cycle against a two-deep FIFO model; a second instance with CNT_W=3 shows saturation.
module tb_pipe_stage_reg;

  localparam int          DATA_W = 32;
  localparam logic [31:0] RV     = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              busywait = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              in_ready, out_valid, in_ready3, out_valid3;
  logic [DATA_W-1:0] out_data, out_data3;
  logic [15:0]       stall_cnt;
  logic [2:0]        stall_cnt3;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: ordered list of held payloads (at most two).
  logic [31:0] mq[$];
  logic [31:0] idle_data = RV;
  longint      stall_n = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .RESET_VALUE(RV), .CNT_W(16)) dut (
    .CLK(clk), .RESET(rst), .FLUSH(flush), .BUSYWAIT(busywait),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .STALL_CNT(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .RESET_VALUE(RV), .CNT_W(3)) dut3 (
    .CLK(clk), .RESET(rst), .FLUSH(flush), .BUSYWAIT(busywait),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready3),
    .OUT_DATA(out_data3), .OUT_VALID(out_valid3), .OUT_READY(out_ready),
    .STALL_CNT(stall_cnt3)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge: drive inputs, advance the model, cross one posedge,
  // then compare at the following negedge.
  task automatic step(input logic r, input logic f, input logic bw,
                      input logic iv, input logic [31:0] d, input logic ordy);
    bit in_acc, out_acc, was_valid;
    logic [31:0] e_data;
    longint e16, e3;
    rst = r; flush = f; busywait = bw; in_valid = iv; in_data = d; out_ready = ordy;
    was_valid = (mq.size() > 0);
    in_acc    = iv && (mq.size() < 2);
    out_acc   = was_valid && ordy && !bw;
    if (r) begin
      mq.delete();
      idle_data = RV;
      stall_n = 0;
    end else begin
      if (was_valid && !out_acc) stall_n++;
      if (f) begin
        mq.delete();
        idle_data = RV;
      end else begin
        if (out_acc) idle_data = mq.pop_front();
        if (in_acc) mq.push_back(d);
      end
    end
    @(posedge clk);
    @(negedge clk);
    e_data = (mq.size() > 0) ? mq[0] : idle_data;
    e16 = (stall_n > 65535) ? 65535 : stall_n;
    e3  = (stall_n > 7) ? 7 : stall_n;
    check_eq("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    check_eq("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    check_eq("out_data", 64'(out_data), 64'(e_data));
    check_eq("stall_cnt", 64'(stall_cnt), 64'(e16));
    check_eq("stall_cnt3", 64'(stall_cnt3), 64'(e3));
    $display("step rst=%0b fl=%0b bw=%0b iv=%0b d=%08h ordy=%0b -> ov=%0b ir=%0b od=%08h sc=%0d sc3=%0d",
             r, f, bw, iv, d, ordy, out_valid, in_ready, out_data, stall_cnt, stall_cnt3);
  endtask

  initial begin
    logic [15:0] saved;
    int seen;

    // 1. Reset for two cycles
    step(1, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 0, 32'h0, 0);
    check_eq("rst_ov", 64'(out_valid), 64'd0);
    check_eq("rst_ir", 64'(in_ready), 64'd1);
    check_eq("rst_od", 64'(out_data), 64'(RV));
    check_eq("rst_sc", 64'(stall_cnt), 64'd0);

    // 2. Streaming 0x11, 0x22, 0x33
    seen = 0;
    step(0, 0, 0, 1, 32'h11, 1); check_eq("strm0", 64'(out_data), 64'h11);
    step(0, 0, 0, 1, 32'h22, 1); check_eq("strm1", 64'(out_data), 64'h22);
    step(0, 0, 0, 1, 32'h33, 1); check_eq("strm2", 64'(out_data), 64'h33);
    for (int i = 0; i < 3; i++) begin
      if (out_valid) seen++;
      step(0, 0, 0, 0, 32'h0, 1);
    end
    check_eq("strm_valid_cycles", 64'(seen + 2), 64'd3);

    // 3. Skid: BUSY holding 0xA, BUSYWAIT while 0xB presented
    step(0, 0, 1, 1, 32'hA, 1);
    step(0, 0, 1, 1, 32'hB, 1);
    check_eq("skid_ir", 64'(in_ready), 64'd0);
    step(0, 0, 0, 0, 32'h0, 1);
    check_eq("skid_ir_back", 64'(in_ready), 64'd1);
    check_eq("skid_first_gone_next_b", 64'(out_data), 64'hB);
    step(0, 0, 0, 0, 32'h0, 1);

    // 4. Flush while FULL with 0xC presented
    step(0, 0, 1, 1, 32'hA, 1);
    step(0, 0, 1, 1, 32'hB, 1);
    saved = stall_cnt;
    step(0, 1, 0, 1, 32'hC, 1);
    check_eq("flush_ov", 64'(out_valid), 64'd0);
    check_eq("flush_od", 64'(out_data), 64'(RV));
    check_eq("flush_sc", 64'(stall_cnt), 64'(saved));
    step(0, 0, 0, 0, 32'h0, 1);
    check_eq("flush_no_c", 64'(out_valid), 64'd0);

    // 5. Stall counting and 3-bit saturation
    step(0, 0, 0, 1, 32'h55, 0);
    saved = stall_cnt;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 32'h0, 0);
    check_eq("stall_plus5", 64'(stall_cnt), 64'(saved + 16'd5));
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 32'h0, 0);
    check_eq("stall3_sat", 64'(stall_cnt3), 64'd7);

    // 6. Reset while FULL under BUSYWAIT
    step(0, 0, 1, 1, 32'h66, 0);
    check_eq("pre_rst_full", 64'(in_ready), 64'd0);
    step(1, 0, 1, 1, 32'h77, 1);
    check_eq("mid_rst_ov", 64'(out_valid), 64'd0);
    check_eq("mid_rst_ir", 64'(in_ready), 64'd1);
    check_eq("mid_rst_sc", 64'(stall_cnt), 64'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(19) == 0),
           ($urandom_range(3) == 0), ($urandom_range(3) != 0),
           $urandom, ($urandom_range(3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
